fifo_sync_fwft: RTL and testbench
=================================

# fifo_sync_fwft

Single-clock, parametrised first-word-fall-through FIFO. It replaces the dual-clock FIFO where both sides share one clock. Over that FIFO it adds the full 2^ADDR_BITS usable depth, occupancy-based programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It sits between on-chip producers and consumers such as bus bridges, UART/VGA line buffers and DMA staging, where read data must be valid without a read strobe.

## Interface
- DATA_BITS, 32, data word width
- ADDR_BITS, 8, address width; depth DEPTH = 2^ADDR_BITS entries, all usable
- clk  input  1  clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- en_w  input  1  write request
- data_w  input  DATA_BITS  write data
- en_r  input  1  read (pop) request; acknowledges current data_r
- data_r  output  DATA_BITS  head-of-FIFO word, valid whenever empty_r=0
- full_w  output  1  count == DEPTH
- empty_r  output  1  count == 0
- near_full_w  output  1  count >= afull_level
- near_empty_r  output  1  count <= aempty_level
- afull_level  input  ADDR_BITS+1  almost-full threshold, quasi-static
- aempty_level  input  ADDR_BITS+1  almost-empty threshold, quasi-static
- data_count  output  ADDR_BITS+1  stored words, 0..DEPTH
- space_count  output  ADDR_BITS+1  DEPTH - data_count
- overflow  output  1  sticky: write attempted while full with no read
- underflow  output  1  sticky: read attempted while empty
- err_clr  input  1  clears overflow/underflow

## Operation
- Storage: DEPTH x DATA_BITS array; ptr_w, ptr_r are ADDR_BITS+1 wide, and the MSB distinguishes full from empty. Pointers wrap modulo 2^(ADDR_BITS+1); the array index is the low ADDR_BITS bits.
- Accepted write: en_w & (~full_w | en_r). Writing while full is legal only together with a read; both are then accepted.
- Accepted read: en_r & ~empty_r. en_r on empty is ignored, ptr_r is unchanged and underflow is set.
- Rejected write: en_w & full_w & ~en_r. Data is dropped and overflow is set.
- Count: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
- FWFT head: data_r always shows the oldest stored word. The structure is array plus an output holding register, with a bypass when writing into an empty FIFO or into a FIFO of count 1 that is being read. No read-enable is needed to present data.
- Comparisons are unsigned on ADDR_BITS+1 bits. afull_level=0 makes near_full_w constantly 1. aempty_level >= DEPTH makes near_empty_r constantly 1.
- Error flags: the set condition wins over err_clr in the same cycle. rst clears them.
- rst mid-operation discards all contents. In the reset cycle, en_w and en_r are ignored.

## Timing
- Reset values: data_count=0, space_count=DEPTH, empty_r=1, full_w=0, near_empty_r=(aempty_level>=0)=1, near_full_w=(afull_level==0), overflow=0, underflow=0, data_r=0.
- data_count, full_w, empty_r and the error flags are registered and update at the edge that accepts the operation.
- near_* flags are combinational from the registered count and the level inputs.
- Write-to-read latency: a word written at edge N into an empty FIFO gives empty_r=0 and data_r=that word in the cycle after edge N.
- Read: with en_r=1 at edge N, data_r shows the next word, or empty_r=1, in the cycle after edge N. Back-to-back reads sustain 1 word/clock.
- Full FIFO with en_w=en_r=1 for K cycles: full_w stays 1, no data is lost, and order is preserved.
- Count 1 with simultaneous read and write: empty_r stays 0, and data_r switches to the new word after the edge.

## Test plan
- Reset, then write 0x11..0x14 on 4 consecutive clocks with en_r=0 -> data_r=0x11 one cycle after the first write; data_count=4; empty_r=0.
- Fill: ADDR_BITS=3, write 8 words -> full_w=1, space_count=0. A 9th write with en_r=0 -> data dropped, overflow=1. err_clr -> overflow=0.
- Full plus simultaneous read/write for 20 cycles -> full_w held at 1, and the read sequence equals the write sequence with no gaps.
- Empty read: en_r=1 at reset state -> underflow=1, data_count stays 0. Then write 0xA5 and pop it on the following cycle -> empty_r=1 the next cycle.
- Thresholds: afull_level=6, aempty_level=2, depth 8. Fill 0→8 then drain 8→0 -> near_full_w asserts at count 6 and near_empty_r asserts at count ≤2, on exact edges.
- Reset during streaming at count 5 -> next cycle count=0, empty_r=1, and old data never reappears on data_r.

Source files
------------

// File: rtl/fifo_sync_fwft.sv
// Single-clock first-word-fall-through FIFO.
// The oldest stored word is always presented on data_r through an output
// holding register, so a consumer only pulses en_r to acknowledge it.
// All DEPTH = 2^ADDR_BITS entries are usable; full and empty come from
// ADDR_BITS+1 wide pointers whose MSB tells a full ring from an empty one.
module fifo_sync_fwft #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_w,
  input  logic [DATA_BITS-1:0] data_w,
  input  logic                 en_r,
  output logic [DATA_BITS-1:0] data_r,
  output logic                 full_w,
  output logic                 empty_r,
  output logic                 near_full_w,
  output logic                 near_empty_r,
  input  logic [ADDR_BITS:0]   afull_level,
  input  logic [ADDR_BITS:0]   aempty_level,
  output logic [ADDR_BITS:0]   data_count,
  output logic [ADDR_BITS:0]   space_count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 err_clr
);

  localparam int               DEPTH_N = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH = (ADDR_BITS+1)'(DEPTH_N);
  localparam logic [ADDR_BITS:0] ONE   = (ADDR_BITS+1)'(1);

  // Storage array and control state
  logic [DATA_BITS-1:0] r_mem [DEPTH_N];
  logic [ADDR_BITS:0]   r_ptr_w;
  logic [ADDR_BITS:0]   r_ptr_r;
  logic [ADDR_BITS:0]   r_count;
  logic [DATA_BITS-1:0] r_head;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_overflow;
  logic                 r_underflow;

  // Combinational helpers
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_ovf_set;
  logic                 w_udf_set;
  logic [ADDR_BITS:0]   w_ptr_w_next;
  logic [ADDR_BITS:0]   w_ptr_r_next;
  logic [ADDR_BITS:0]   w_ptr_r_inc;
  logic [ADDR_BITS:0]   w_count_next;
  logic [DATA_BITS-1:0] w_head_next;
  logic                 w_full_next;
  logic                 w_empty_next;

  // Decide which requests are accepted; a write on a full FIFO is only
  // taken when a read frees the head slot in the same cycle.
  always_comb begin
    w_rd_acc  = en_r & ~r_empty;
    w_wr_acc  = en_w & (~r_full | en_r);
    w_ovf_set = en_w & r_full & ~en_r;
    w_udf_set = en_r & r_empty;
  end

  // Next pointers, occupancy and full/empty derived from the next pointers.
  always_comb begin
    w_ptr_r_inc  = r_ptr_r + ONE;
    w_ptr_w_next = w_wr_acc ? (r_ptr_w + ONE) : r_ptr_w;
    w_ptr_r_next = w_rd_acc ? w_ptr_r_inc : r_ptr_r;
    w_count_next = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_next = r_count + ONE;
      2'b01:   w_count_next = r_count - ONE;
      default: w_count_next = r_count;
    endcase
    w_empty_next = (w_ptr_w_next == w_ptr_r_next);
    w_full_next  = (w_ptr_w_next[ADDR_BITS] != w_ptr_r_next[ADDR_BITS]) &&
                   (w_ptr_w_next[ADDR_BITS-1:0] == w_ptr_r_next[ADDR_BITS-1:0]);
  end

  // Next head word: bypass the incoming word when it becomes the oldest
  // entry (empty FIFO, or count 1 being popped), otherwise fetch the entry
  // after the current head from the array when the head is consumed.
  always_comb begin
    w_head_next = r_head;
    if (w_wr_acc && (r_empty || ((r_count == ONE) && w_rd_acc))) begin
      w_head_next = data_w;
    end else if (w_rd_acc && (r_count > ONE)) begin
      w_head_next = r_mem[w_ptr_r_inc[ADDR_BITS-1:0]];
    end
  end

  // Array write port; contents need no reset since the pointers define
  // which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_ptr_w[ADDR_BITS-1:0]] <= data_w;
    end
  end

  // Pointer, occupancy, head and status registers with synchronous reset
  // that discards all contents and ignores requests in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr_w <= '0;
      r_ptr_r <= '0;
      r_count <= '0;
      r_head  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_ptr_w <= w_ptr_w_next;
      r_ptr_r <= w_ptr_r_next;
      r_count <= w_count_next;
      r_head  <= w_head_next;
      r_full  <= w_full_next;
      r_empty <= w_empty_next;
    end
  end

  // Sticky error flags; a new error event wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow & ~err_clr);
      r_underflow <= w_udf_set | (r_underflow & ~err_clr);
    end
  end

  // Output mapping; threshold flags are unsigned compares on the count.
  always_comb begin
    data_r       = r_head;
    full_w       = r_full;
    empty_r      = r_empty;
    data_count   = r_count;
    space_count  = DEPTH - r_count;
    near_full_w  = (r_count >= afull_level);
    near_empty_r = (r_count <= aempty_level);
    overflow     = r_overflow;
    underflow    = r_underflow;
  end

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Directed testbench for fifo_sync_fwft with an 8-entry configuration.
module tb_fifo_sync_fwft;

  localparam int DATA_BITS = 32;
  localparam int ADDR_BITS = 3;

  logic                 clk;
  logic                 rst;
  logic                 en_w;
  logic [DATA_BITS-1:0] data_w;
  logic                 en_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 full_w;
  logic                 empty_r;
  logic                 near_full_w;
  logic                 near_empty_r;
  logic [ADDR_BITS:0]   afull_level;
  logic [ADDR_BITS:0]   aempty_level;
  logic [ADDR_BITS:0]   data_count;
  logic [ADDR_BITS:0]   space_count;
  logic                 overflow;
  logic                 underflow;
  logic                 err_clr;

  int nCompared;
  int nMismatched;
  logic [DATA_BITS-1:0] expQ[$];

  fifo_sync_fwft #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_w(en_w),
    .data_w(data_w),
    .en_r(en_r),
    .data_r(data_r),
    .full_w(full_w),
    .empty_r(empty_r),
    .near_full_w(near_full_w),
    .near_empty_r(near_empty_r),
    .afull_level(afull_level),
    .aempty_level(aempty_level),
    .data_count(data_count),
    .space_count(space_count),
    .overflow(overflow),
    .underflow(underflow),
    .err_clr(err_clr)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of requests, then settle just after the edge
  task automatic applyStimulus(input logic wr, input logic [DATA_BITS-1:0] d, input logic rd);
    en_w   = wr;
    data_w = d;
    en_r   = rd;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value to its expectation
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Near flags and count against the queue model
  task automatic checkLevels(input string tag);
    checkOutput({tag, "_count"}, 64'(data_count), 64'(expQ.size()));
    checkOutput({tag, "_nfull"}, 64'(near_full_w), 64'(expQ.size() >= 6));
    checkOutput({tag, "_nempty"}, 64'(near_empty_r), 64'(expQ.size() <= 2));
  endtask

  initial begin
    nCompared    = 0;
    nMismatched  = 0;
    rst          = 1'b1;
    en_w         = 1'b0;
    en_r         = 1'b0;
    data_w       = '0;
    err_clr      = 1'b0;
    afull_level  = 4'd6;
    aempty_level = 4'd2;

    // Reset state
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b0;
    checkOutput("rst_count", 64'(data_count), 64'd0);
    checkOutput("rst_space", 64'(space_count), 64'd8);
    checkOutput("rst_empty", 64'(empty_r), 64'd1);
    checkOutput("rst_full", 64'(full_w), 64'd0);
    checkOutput("rst_nempty", 64'(near_empty_r), 64'd1);
    checkOutput("rst_nfull", 64'(near_full_w), 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    checkOutput("rst_udf", 64'(underflow), 64'd0);
    checkOutput("rst_data", 64'(data_r), 64'd0);
    afull_level = 4'd0;
    #1;
    checkOutput("afull0_nfull", 64'(near_full_w), 64'd1);
    afull_level = 4'd6;
    #1;

    // Four writes, FWFT latency, then drain in order
    applyStimulus(1'b1, 32'h11, 1'b0);
    checkOutput("w1_data", 64'(data_r), 64'h11);
    checkOutput("w1_empty", 64'(empty_r), 64'd0);
    applyStimulus(1'b1, 32'h12, 1'b0);
    applyStimulus(1'b1, 32'h13, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b0);
    checkOutput("w4_count", 64'(data_count), 64'd4);
    checkOutput("w4_data", 64'(data_r), 64'h11);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("r1_data", 64'(data_r), 64'h12);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("r2_data", 64'(data_r), 64'h13);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("r3_data", 64'(data_r), 64'h14);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("r4_empty", 64'(empty_r), 64'd1);
    checkOutput("r4_count", 64'(data_count), 64'd0);

    // Read on empty sets underflow, clear, then set wins over clear
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("udf_set", 64'(underflow), 64'd1);
    checkOutput("udf_count", 64'(data_count), 64'd0);
    err_clr = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("udf_clr", 64'(underflow), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("udf_setwins", 64'(underflow), 64'd1);
    applyStimulus(1'b0, '0, 1'b0);
    err_clr = 1'b0;
    checkOutput("udf_clr2", 64'(underflow), 64'd0);

    // Single word in and straight out
    applyStimulus(1'b1, 32'hA5, 1'b0);
    checkOutput("a5_data", 64'(data_r), 64'hA5);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("a5_empty", 64'(empty_r), 64'd1);

    // Count 1 with simultaneous read and write
    applyStimulus(1'b1, 32'hB1, 1'b0);
    applyStimulus(1'b1, 32'hB2, 1'b1);
    checkOutput("c1_empty", 64'(empty_r), 64'd0);
    checkOutput("c1_count", 64'(data_count), 64'd1);
    checkOutput("c1_data", 64'(data_r), 64'hB2);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("c1_drain", 64'(empty_r), 64'd1);

    // Fill 0 -> 8 watching thresholds at every edge
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0);
      expQ.push_back(32'h100 + 32'(i));
      checkLevels($sformatf("fill%0d", i + 1));
    end
    checkOutput("fill_full", 64'(full_w), 64'd1);
    checkOutput("fill_space", 64'(space_count), 64'd0);
    aempty_level = 4'd8;
    #1;
    checkOutput("aempty8_nempty", 64'(near_empty_r), 64'd1);
    aempty_level = 4'd2;
    #1;

    // Ninth write is dropped and flagged
    applyStimulus(1'b1, 32'hDEAD, 1'b0);
    checkOutput("ovf_set", 64'(overflow), 64'd1);
    checkOutput("ovf_count", 64'(data_count), 64'd8);
    checkOutput("ovf_head", 64'(data_r), 64'h100);
    err_clr = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    err_clr = 1'b0;
    checkOutput("ovf_clr", 64'(overflow), 64'd0);

    // Full with read and write together for 20 cycles
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 32'h200 + 32'(k), 1'b1);
      void'(expQ.pop_front());
      expQ.push_back(32'h200 + 32'(k));
      checkOutput($sformatf("stream%0d_full", k), 64'(full_w), 64'd1);
      checkOutput($sformatf("stream%0d_data", k), 64'(data_r), 64'(expQ[0]));
    end
    checkOutput("stream_ovf", 64'(overflow), 64'd0);

    // Drain 8 -> 0 watching thresholds and order
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      void'(expQ.pop_front());
      checkLevels($sformatf("drain%0d", i + 1));
      if (expQ.size() > 0) begin
        checkOutput($sformatf("drain%0d_data", i + 1), 64'(data_r), 64'(expQ[0]));
      end
    end
    checkOutput("drain_empty", 64'(empty_r), 64'd1);

    // Reset while streaming at count 5
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0);
    end
    checkOutput("pre_rst_count", 64'(data_count), 64'd5);
    rst = 1'b1;
    applyStimulus(1'b1, 32'h399, 1'b1);
    rst = 1'b0;
    checkOutput("mid_rst_count", 64'(data_count), 64'd0);
    checkOutput("mid_rst_empty", 64'(empty_r), 64'd1);
    checkOutput("mid_rst_data", 64'(data_r), 64'd0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("post_rst_data", 64'(data_r), 64'd0);
    checkOutput("post_rst_empty", 64'(empty_r), 64'd1);
    applyStimulus(1'b1, 32'h3AA, 1'b0);
    checkOutput("post_rst_new", 64'(data_r), 64'h3AA);
    checkOutput("post_rst_cnt", 64'(data_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
